// File: rtl/tcdm_to_reqrsp_pkg.sv
// Shared sizing helpers and default bus structs for the TCDM -> reqrsp bridge.
// The structs mirror what the REQRSP/TCDM typedef macros generate for 32b addr / 64b data.
package tcdm_to_reqrsp_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefStrbWidth = DefDataWidth / 8;

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  // reqrsp size encoding for an access spanning the whole data bus
  function automatic logic [2:0] full_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  typedef logic [DefAddrWidth-1:0] def_addr_t;
  typedef logic [DefDataWidth-1:0] def_data_t;
  typedef logic [DefStrbWidth-1:0] def_strb_t;

  typedef struct packed {
    def_addr_t   addr;
    logic        write;
    logic [3:0]  amo;
    def_data_t   data;
    def_strb_t   strb;
    logic        user;
  } def_tcdm_req_chan_t;

  typedef struct packed {
    def_tcdm_req_chan_t q;
    logic               q_valid;
  } def_tcdm_req_t;

  typedef struct packed {
    def_data_t data;
  } def_tcdm_rsp_chan_t;

  typedef struct packed {
    def_tcdm_rsp_chan_t p;
    logic               p_valid;
    logic               q_ready;
  } def_tcdm_rsp_t;

  typedef struct packed {
    def_addr_t   addr;
    logic        write;
    logic [3:0]  amo;
    def_data_t   data;
    def_strb_t   strb;
    logic [2:0]  size;
  } def_reqrsp_req_chan_t;

  typedef struct packed {
    def_reqrsp_req_chan_t q;
    logic                 q_valid;
    logic                 p_ready;
  } def_reqrsp_req_t;

  typedef struct packed {
    def_data_t data;
    logic      error;
  } def_reqrsp_rsp_chan_t;

  typedef struct packed {
    def_reqrsp_rsp_chan_t p;
    logic                 p_valid;
    logic                 q_ready;
  } def_reqrsp_rsp_t;

endpackage

// File: rtl/tcdm_to_reqrsp_req_slice.sv
// One-entry valid/ready register with synchronous active-high reset; Bypass=1 makes it a wire.
// Full throughput: a full entry can be replaced in the same cycle it drains.
module tcdm_to_reqrsp_req_slice
  import tcdm_to_reqrsp_pkg::*;
#(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : g_bypass
    logic w_unused_clk;
    assign w_unused_clk = clk_i ^ rst_i;
    assign valid_o      = valid_i;
    assign ready_o      = ready_i;
    assign data_o       = data_i;
  end else begin : g_reg
    logic r_full;
    T     r_data;

    assign valid_o = r_full;
    assign ready_o = ~r_full | ready_i;
    assign data_o  = r_data;

    // r_data only loads on acceptance, so it stays stable while stalled
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (valid_i && ready_o) begin
        r_full <= 1'b1;
        r_data <= data_i;
      end else if (ready_i) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tcdm_to_reqrsp.sv
// TCDM initiator -> reqrsp bridge. Credits bound outstanding requests because TCDM
// responses cannot be back-pressured; reqrsp errors collect in a sticky flag.
module tcdm_to_reqrsp
  import tcdm_to_reqrsp_pkg::*;
#(
  parameter int unsigned AddrWidth      = DefAddrWidth,
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          RegisterReq    = 1'b1,
  parameter type tcdm_req_t             = def_tcdm_req_t,
  parameter type tcdm_rsp_t             = def_tcdm_rsp_t,
  parameter type reqrsp_req_chan_t      = def_reqrsp_req_chan_t,
  parameter type reqrsp_req_t           = def_reqrsp_req_t,
  parameter type reqrsp_rsp_t           = def_reqrsp_rsp_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  tcdm_req_t                              tcdm_req_i,
  output tcdm_rsp_t                              tcdm_rsp_o,
  output reqrsp_req_t                            reqrsp_req_o,
  input  reqrsp_rsp_t                            reqrsp_rsp_i,
  output logic                                   err_o,
  input  logic                                   err_clr_i,
  output logic [cnt_width(MaxOutstanding)-1:0]   outstanding_o
);

  localparam int unsigned     CntW     = cnt_width(MaxOutstanding);
  localparam logic [2:0]      FullSize = full_size(DataWidth);
  localparam logic [CntW-1:0] CntMax   = CntW'(MaxOutstanding);

  logic [CntW-1:0]      r_cnt;
  logic                 r_p_valid;
  logic [DataWidth-1:0] r_p_data;
  logic                 r_err;

  logic                 w_credit_ok;
  logic                 w_slice_rdy;
  logic                 w_slice_valid;
  logic                 w_tcdm_hs;
  logic                 w_rsp_hs;
  logic [AddrWidth-1:0] w_addr;
  logic                 w_unused_user;
  reqrsp_req_chan_t     w_q;
  reqrsp_req_chan_t     w_slice_q;

  // Credit check uses only the registered count, so q_ready never sees p_valid.
  assign w_credit_ok   = r_cnt < CntMax;
  assign w_tcdm_hs     = tcdm_req_i.q_valid & w_credit_ok & w_slice_rdy;
  assign w_rsp_hs      = reqrsp_rsp_i.p_valid;
  assign w_addr        = tcdm_req_i.q.addr;
  assign w_unused_user = ^tcdm_req_i.q.user;

  always_comb begin
    w_q       = '0;
    w_q.addr  = w_addr;
    w_q.write = tcdm_req_i.q.write;
    w_q.amo   = tcdm_req_i.q.amo;
    w_q.data  = tcdm_req_i.q.data;
    w_q.strb  = tcdm_req_i.q.strb;
    w_q.size  = FullSize;
  end

  tcdm_to_reqrsp_req_slice #(
    .T      (reqrsp_req_chan_t),
    .Bypass (!RegisterReq)
  ) i_req_slice (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (tcdm_req_i.q_valid & w_credit_ok),
    .ready_o (w_slice_rdy),
    .data_i  (w_q),
    .valid_o (w_slice_valid),
    .ready_i (reqrsp_rsp_i.q_ready),
    .data_o  (w_slice_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_tcdm_hs && !w_rsp_hs) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (!w_tcdm_hs && w_rsp_hs && r_cnt != '0) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p_valid <= 1'b0;
      r_p_data  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_p_valid <= reqrsp_rsp_i.p_valid;
      if (reqrsp_rsp_i.p_valid) r_p_data <= reqrsp_rsp_i.p.data;
      if (reqrsp_rsp_i.p_valid && reqrsp_rsp_i.p.error) r_err <= 1'b1;
      else if (err_clr_i)                                r_err <= 1'b0;
    end
  end

  always_comb begin
    tcdm_rsp_o           = '0;
    tcdm_rsp_o.q_ready   = w_credit_ok & w_slice_rdy;
    tcdm_rsp_o.p_valid   = r_p_valid;
    tcdm_rsp_o.p.data    = r_p_data;
    reqrsp_req_o         = '0;
    reqrsp_req_o.q       = w_slice_q;
    reqrsp_req_o.q_valid = w_slice_valid;
    reqrsp_req_o.p_ready = 1'b1;
  end

  assign err_o         = r_err;
  assign outstanding_o = r_cnt;

  // A response with no credit outstanding means the slave broke the protocol.
  a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_rsp_hs && r_cnt == '0));

endmodule

// File: tb/tb_tcdm_to_reqrsp.sv
// Bench for tcdm_to_reqrsp: instance 0 registers the request path, instance 1 bypasses it.
// A transaction-level model is compared against both on every falling edge.
module tb_tcdm_to_reqrsp;
  import tcdm_to_reqrsp_pkg::*;

  localparam int MaxOut = 4;
  localparam int CW     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  def_tcdm_req_t   treq [2];
  def_tcdm_rsp_t   trsp [2];
  def_reqrsp_req_t rreq [2];
  def_reqrsp_rsp_t rrsp [2];
  logic            err     [2];
  logic            err_clr [2];
  logic [CW-1:0]   outst   [2];

  tcdm_to_reqrsp #(.MaxOutstanding(MaxOut), .RegisterReq(1'b1)) dut_reg (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(treq[0]), .tcdm_rsp_o(trsp[0]),
    .reqrsp_req_o(rreq[0]), .reqrsp_rsp_i(rrsp[0]), .err_o(err[0]),
    .err_clr_i(err_clr[0]), .outstanding_o(outst[0])
  );

  tcdm_to_reqrsp #(.MaxOutstanding(MaxOut), .RegisterReq(1'b0)) dut_byp (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(treq[1]), .tcdm_rsp_o(trsp[1]),
    .reqrsp_req_o(rreq[1]), .reqrsp_rsp_i(rrsp[1]), .err_o(err[1]),
    .err_clr_i(err_clr[1]), .outstanding_o(outst[1])
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string nm(input int m, input string s);
    return $sformatf("m%0d_%s", m, s);
  endfunction

  // ---------------- transaction-level model ----------------
  int                   mcnt  [2];
  bit                   mfull [2];
  def_reqrsp_req_chan_t mq    [2];
  bit                   mpv   [2];
  logic [63:0]          mpd   [2];
  bit                   merr  [2];
  int                   spend [2];

  function automatic def_reqrsp_req_chan_t map_q(input def_tcdm_req_chan_t t);
    def_reqrsp_req_chan_t r;
    r = '0;
    r.addr = t.addr; r.write = t.write; r.amo = t.amo;
    r.data = t.data; r.strb  = t.strb;  r.size = 3'd3;
    return r;
  endfunction

  function automatic bit exp_qready(input int m);
    bit room;
    room = (m == 0) ? (!mfull[m] || rrsp[m].q_ready) : rrsp[m].q_ready;
    return (mcnt[m] < MaxOut) && room;
  endfunction

  function automatic bit exp_rvalid(input int m);
    return (m == 0) ? mfull[m] : (treq[m].q_valid && mcnt[m] < MaxOut);
  endfunction

  function automatic def_reqrsp_req_chan_t exp_rq(input int m);
    return (m == 0) ? mq[m] : map_q(treq[m].q);
  endfunction

  function automatic bit hs_f(input int m);
    return treq[m].q_valid && exp_qready(m);
  endfunction

  function automatic int next_cnt(input int m);
    int n;
    n = mcnt[m] + int'(hs_f(m)) - int'(rrsp[m].p_valid);
    return (n < 0) ? 0 : n;
  endfunction

  function automatic int next_spend(input int m);
    int n;
    n = spend[m] + int'(exp_rvalid(m) && rrsp[m].q_ready) - int'(rrsp[m].p_valid);
    return (n < 0) ? 0 : n;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mcnt[m] <= 0; mfull[m] <= 1'b0; mq[m] <= '0; mpv[m] <= 1'b0;
        mpd[m] <= '0; merr[m] <= 1'b0; spend[m] <= 0;
      end else begin
        if (mfull[m] && rrsp[m].q_ready) mfull[m] <= 1'b0;
        if (hs_f(m)) begin
          mfull[m] <= 1'b1;
          mq[m]    <= map_q(treq[m].q);
        end
        mcnt[m]  <= next_cnt(m);
        spend[m] <= next_spend(m);
        mpv[m]   <= rrsp[m].p_valid;
        if (rrsp[m].p_valid) mpd[m] <= rrsp[m].p.data;
        if (rrsp[m].p_valid && rrsp[m].p.error) merr[m] <= 1'b1;
        else if (err_clr[m])                    merr[m] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk(nm(m, "q_ready"), trsp[m].q_ready, exp_qready(m));
        chk(nm(m, "rq_valid"), rreq[m].q_valid, exp_rvalid(m));
        if (exp_rvalid(m)) chk(nm(m, "rq_fields"), rreq[m].q, exp_rq(m));
        chk(nm(m, "p_ready"), rreq[m].p_ready, 1'b1);
        chk(nm(m, "p_valid"), trsp[m].p_valid, mpv[m]);
        chk(nm(m, "p_data"), trsp[m].p.data, mpd[m]);
        chk(nm(m, "err"), err[m], merr[m]);
        chk(nm(m, "outstanding"), outst[m], mcnt[m]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nx;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle(input int m);
    treq[m] = '0;
    rrsp[m] = '0;
    rrsp[m].q_ready = 1'b1;
    err_clr[m] = 1'b0;
  endtask

  task automatic run_dir(input int m);
    bit r;
    int n;
    r = (m == 0);
    // single full-width write, slave answers the cycle after it sees the request
    nx; idle(m);
    treq[m].q_valid = 1'b1; treq[m].q.addr = 32'h100; treq[m].q.write = 1'b1;
    treq[m].q.data = 64'hDEADBEEF_CAFEF00D; treq[m].q.strb = 8'hFF;
    smp; chk(nm(m, "wr_qready"), trsp[m].q_ready, 1'b1);
    if (!r) begin
      chk(nm(m, "wr_lat0_valid"), rreq[m].q_valid, 1'b1);
      chk(nm(m, "wr_lat0_size"), rreq[m].q.size, 3'd3);
    end
    nx; treq[m].q_valid = 1'b0;
    smp;
    if (r) begin
      chk(nm(m, "wr_lat1_valid"), rreq[m].q_valid, 1'b1);
      chk(nm(m, "wr_lat1_size"), rreq[m].q.size, 3'd3);
      chk(nm(m, "wr_lat1_write"), rreq[m].q.write, 1'b1);
      chk(nm(m, "wr_lat1_addr"), rreq[m].q.addr, 32'h100);
    end
    chk(nm(m, "wr_out1"), outst[m], 3'd1);
    nx; rrsp[m].p_valid = 1'b1; rrsp[m].p.data = 64'h1234_5678;
    smp; chk(nm(m, "wr_pv_early"), trsp[m].p_valid, 1'b0);
    nx; rrsp[m].p_valid = 1'b0;
    smp; chk(nm(m, "wr_pv"), trsp[m].p_valid, 1'b1);
    chk(nm(m, "wr_pdata"), trsp[m].p.data, 64'h1234_5678);
    chk(nm(m, "wr_out0"), outst[m], 3'd0);

    // credit limit with responses withheld
    nx; treq[m].q = '0; treq[m].q_valid = 1'b1; treq[m].q.addr = 32'h400;
    n = 0;
    repeat (6) begin smp; if (trsp[m].q_ready) n++; nx; end
    chk(nm(m, "crd_hs"), n, 4);
    smp; chk(nm(m, "crd_out4"), outst[m], 3'd4);
    chk(nm(m, "crd_full_qready"), trsp[m].q_ready, 1'b0);
    nx; rrsp[m].p_valid = 1'b1; rrsp[m].p.data = 64'h1;
    smp; chk(nm(m, "crd_same_cycle"), trsp[m].q_ready, 1'b0);
    nx; rrsp[m].p_valid = 1'b0;
    smp; chk(nm(m, "crd_next_cycle"), trsp[m].q_ready, 1'b1);
    nx; treq[m].q_valid = 1'b0; rrsp[m].p_valid = 1'b1;
    repeat (4) nx;
    rrsp[m].p_valid = 1'b0;
    smp; chk(nm(m, "crd_drain"), outst[m], 3'd0);

    // reqrsp stall with a request pending
    nx; treq[m].q = '0; treq[m].q_valid = 1'b1; treq[m].q.addr = 32'h200;
    treq[m].q.strb = 8'h0F; rrsp[m].q_ready = 1'b0;
    if (r) begin
      smp; chk(nm(m, "stl_accept"), trsp[m].q_ready, 1'b1);
      nx; treq[m].q.addr = 32'h300; treq[m].q.strb = 8'hF0;
    end
    repeat (5) begin
      smp;
      chk(nm(m, "stl_qready"), trsp[m].q_ready, 1'b0);
      chk(nm(m, "stl_rvalid"), rreq[m].q_valid, 1'b1);
      chk(nm(m, "stl_addr"), rreq[m].q.addr, 32'h200);
      chk(nm(m, "stl_strb"), rreq[m].q.strb, 8'h0F);
      nx;
    end
    rrsp[m].q_ready = 1'b1;
    if (r) treq[m].q_valid = 1'b0;
    smp; chk(nm(m, "stl_release_addr"), rreq[m].q.addr, 32'h200);
    nx; treq[m].q_valid = 1'b0; rrsp[m].p_valid = 1'b1; rrsp[m].p.data = 64'h2;
    nx; rrsp[m].p_valid = 1'b0;
    smp; chk(nm(m, "stl_out0"), outst[m], 3'd0);

    // error flag: set, set-beats-clear, later clear
    nx; treq[m].q = '0; treq[m].q_valid = 1'b1;
    nx;
    nx; treq[m].q_valid = 1'b0;
    rrsp[m].p_valid = 1'b1; rrsp[m].p.data = 64'h55; rrsp[m].p.error = 1'b1;
    nx; rrsp[m].p_valid = 1'b0; rrsp[m].p.error = 1'b0;
    smp; chk(nm(m, "err_data"), trsp[m].p.data, 64'h55);
    chk(nm(m, "err_set"), err[m], 1'b1);
    nx; rrsp[m].p_valid = 1'b1; rrsp[m].p.error = 1'b1; rrsp[m].p.data = 64'h66;
    err_clr[m] = 1'b1;
    nx; rrsp[m].p_valid = 1'b0; rrsp[m].p.error = 1'b0;
    smp; chk(nm(m, "err_set_wins"), err[m], 1'b1);
    nx; err_clr[m] = 1'b0;
    smp; chk(nm(m, "err_cleared"), err[m], 1'b0);
    chk(nm(m, "err_out0"), outst[m], 3'd0);

    // simultaneous credit take and return at cnt=2
    nx; treq[m].q = '0; treq[m].q_valid = 1'b1;
    nx;
    nx; rrsp[m].p_valid = 1'b1; rrsp[m].p.data = 64'h7;
    smp; chk(nm(m, "sim_pre"), outst[m], 3'd2);
    nx; treq[m].q_valid = 1'b0; rrsp[m].p_valid = 1'b0;
    smp; chk(nm(m, "sim_hold"), outst[m], 3'd2);
    nx; rrsp[m].p_valid = 1'b1;
    nx;
    nx; rrsp[m].p_valid = 1'b0;
    smp; chk(nm(m, "sim_drain"), outst[m], 3'd0);

    // reset with cnt=3, error set and (registered mode) the slice full
    nx; treq[m].q = '0; treq[m].q_valid = 1'b1;
    repeat (3) nx;
    nx; treq[m].q_valid = 1'b0;
    if (r) rrsp[m].q_ready = 1'b0;
    rrsp[m].p_valid = 1'b1; rrsp[m].p.error = 1'b1; rrsp[m].p.data = 64'h9;
    smp; chk(nm(m, "rst_pre_out4"), outst[m], 3'd4);
    if (r) chk(nm(m, "rst_pre_full"), rreq[m].q_valid, 1'b1);
    nx; rrsp[m].p_valid = 1'b0; rrsp[m].p.error = 1'b0; rst = 1'b1;
    smp; chk(nm(m, "rst_pre_out3"), outst[m], 3'd3);
    chk(nm(m, "rst_pre_err"), err[m], 1'b1);
    nx; rst = 1'b0; rrsp[m].q_ready = 1'b1;
    smp; chk(nm(m, "rst_out"), outst[m], 3'd0);
    chk(nm(m, "rst_rvalid"), rreq[m].q_valid, 1'b0);
    chk(nm(m, "rst_pvalid"), trsp[m].p_valid, 1'b0);
    chk(nm(m, "rst_pdata"), trsp[m].p.data, 64'h0);
    chk(nm(m, "rst_err"), err[m], 1'b0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) idle(m);
    rst = 1'b1;
    nx; chk_en = 1'b1;
    nx; rst = 1'b0;
    smp;
    for (int m = 0; m < 2; m++) begin
      chk(nm(m, "reset_out"), outst[m], 3'd0);
      chk(nm(m, "reset_rvalid"), rreq[m].q_valid, 1'b0);
      chk(nm(m, "reset_pvalid"), trsp[m].p_valid, 1'b0);
      chk(nm(m, "reset_pdata"), trsp[m].p.data, 64'h0);
      chk(nm(m, "reset_err"), err[m], 1'b0);
    end

    run_dir(0);
    run_dir(1);

    nx; rst = 1'b1;
    nx; rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int m = 0; m < 2; m++) begin
        treq[m].q_valid    = ($urandom_range(0, 3) != 0);
        treq[m].q.addr     = $urandom;
        treq[m].q.write    = 1'($urandom);
        treq[m].q.amo      = 4'($urandom);
        treq[m].q.data     = {$urandom, $urandom};
        treq[m].q.strb     = 8'($urandom);
        treq[m].q.user     = 1'($urandom);
        rrsp[m].q_ready    = ($urandom_range(0, 3) != 0);
        rrsp[m].p_valid    = (spend[m] > 0) &&
                             ((c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
        rrsp[m].p.data     = {$urandom, $urandom};
        rrsp[m].p.error    = ($urandom_range(0, 7) == 0);
        err_clr[m]         = ($urandom_range(0, 7) == 0);
      end
      nx;
    end
    for (int m = 0; m < 2; m++) idle(m);
    nx;
    smp;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
